// File: rtl/mem_wb_stage.sv
// Writeback stage of the 3-stage RISC-V pipeline: load alignment, writeback select,
// forwarding history and the tohost CSR. Optional perf counters under WB_PERF_CNT_EN.
module mem_wb_stage #(
   parameter logic [31:0] RESET_PC_NOP    = 32'h0000_0013,
   parameter logic [11:0] CSR_TOHOST_ADDR = 12'h51E
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        x_valid,
   input  logic [31:0] x_inst,
   input  logic [31:0] x_pc,
   input  logic [31:0] x_alu_out,
   input  logic [31:0] x_csr_src,
   input  logic [31:0] dcache_dout,
   output logic [31:0] wb_inst,
   output logic [31:0] wb_prev_inst,
   output logic [31:0] wb_data,
   output logic [31:0] wb_prev_data,
   output logic        rf_we,
   output logic [4:0]  rf_wa,
   output logic [31:0] rf_wd,
   output logic [31:0] csr_tohost
);

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   logic        wb_valid;
   logic [31:0] wb_pc4;
   logic [31:0] wb_alu;
   logic [31:0] wb_csr_src;
   logic [4:0]  wb_zimm;

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [4:0]  rd;
   logic [11:0] csr_addr;
   logic [31:0] load_data;
   logic [31:0] csr_rd_data;
   logic        csr_rd_hit;
   logic        wr_op;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   assign opcode   = wb_inst[6:0];
   assign funct3   = wb_inst[14:12];
   assign rd       = wb_inst[11:7];
   assign csr_addr = wb_inst[31:20];

`ifdef WB_PERF_CNT_EN
   logic [31:0] cnt_cycle;
   logic [31:0] cnt_instret;

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_cycle   <= '0;
         cnt_instret <= '0;
      end else begin
         cnt_cycle <= cnt_cycle + 32'd1;
         if (!stall && wb_valid) cnt_instret <= cnt_instret + 32'd1;
      end
   end

   // csrr rd, cycle/instret (csrrs with any rs1 reads the counter value)
   always_comb begin
      csr_rd_hit  = 1'b0;
      csr_rd_data = '0;
      if (opcode == OP_SYSTEM && funct3 == 3'b010) begin
         if (csr_addr == 12'hC00) begin
            csr_rd_hit  = 1'b1;
            csr_rd_data = cnt_cycle;
         end else if (csr_addr == 12'hC02) begin
            csr_rd_hit  = 1'b1;
            csr_rd_data = cnt_instret;
         end
      end
   end
`else
   assign csr_rd_hit  = 1'b0;
   assign csr_rd_data = '0;
`endif

   always_comb begin
      case (wb_alu[1:0])
         2'd0:    ld_byte = dcache_dout[7:0];
         2'd1:    ld_byte = dcache_dout[15:8];
         2'd2:    ld_byte = dcache_dout[23:16];
         default: ld_byte = dcache_dout[31:24];
      endcase
      ld_half = wb_alu[1] ? dcache_dout[31:16] : dcache_dout[15:0];
   end

   always_comb begin
      case (funct3)
         3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
         3'b100:  load_data = {24'b0, ld_byte};
         3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
         3'b101:  load_data = {16'b0, ld_half};
         default: load_data = dcache_dout;
      endcase
   end

   always_comb begin
      wr_op   = 1'b0;
      wb_data = '0;
      case (opcode)
         OP_LOAD: begin
            wr_op   = 1'b1;
            wb_data = load_data;
         end
         OP_JAL, OP_JALR: begin
            wr_op   = 1'b1;
            wb_data = wb_pc4;
         end
         OP_LUI, OP_AUIPC, OP_REG, OP_IMM: begin
            wr_op   = 1'b1;
            wb_data = wb_alu;
         end
         OP_SYSTEM: wb_data = csr_rd_data;
         default: ;
      endcase
   end

   assign rf_we = !reset && !stall && wb_valid && (rd != 5'd0) && (wr_op || csr_rd_hit);
   assign rf_wa = rd;
   assign rf_wd = wb_data;

   always_ff @(posedge clk) begin
      if (reset) begin
         wb_inst      <= RESET_PC_NOP;
         wb_prev_inst <= RESET_PC_NOP;
         wb_valid     <= 1'b0;
         wb_prev_data <= '0;
         wb_pc4       <= '0;
         wb_alu       <= '0;
         wb_csr_src   <= '0;
         wb_zimm      <= '0;
         csr_tohost   <= '0;
      end else if (!stall) begin
         wb_inst      <= x_valid ? x_inst : RESET_PC_NOP;
         wb_valid     <= x_valid;
         wb_pc4       <= x_pc + 32'd4;
         wb_alu       <= x_alu_out;
         wb_csr_src   <= x_csr_src;
         wb_zimm      <= x_inst[19:15];
         wb_prev_inst <= wb_inst;
         wb_prev_data <= wb_data;
         // tohost commits on the edge that retires the csr instruction
         if (wb_valid && opcode == OP_SYSTEM && csr_addr == CSR_TOHOST_ADDR) begin
            case (funct3)
               3'b001:  csr_tohost <= wb_csr_src;
               3'b101:  csr_tohost <= {27'b0, wb_zimm};
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed scenarios plus a randomized run against a behavioural model.
module tb_mem_wb_stage;

   logic        clk = 1'b0;
   logic        reset, stall, x_valid;
   logic [31:0] x_inst, x_pc, x_alu_out, x_csr_src, dcache_dout;
   logic [31:0] wb_inst, wb_prev_inst, wb_data, wb_prev_data, rf_wd, csr_tohost;
   logic        rf_we;
   logic [4:0]  rf_wa;

   int checks = 0;
   int failures = 0;

   localparam logic [31:0] NOP = 32'h0000_0013;

   mem_wb_stage dut (
      .clk(clk), .reset(reset), .stall(stall), .x_valid(x_valid),
      .x_inst(x_inst), .x_pc(x_pc), .x_alu_out(x_alu_out), .x_csr_src(x_csr_src),
      .dcache_dout(dcache_dout), .wb_inst(wb_inst), .wb_prev_inst(wb_prev_inst),
      .wb_data(wb_data), .wb_prev_data(wb_prev_data), .rf_we(rf_we), .rf_wa(rf_wa),
      .rf_wd(rf_wd), .csr_tohost(csr_tohost)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic present(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                          input logic [31:0] alu, input logic [31:0] csr);
      x_valid = v; x_inst = inst; x_pc = pc; x_alu_out = alu; x_csr_src = csr; stall = 1'b0;
      tick();
   endtask

   // Expected writeback value derived from the ISA meaning of the instruction
   function automatic logic [31:0] ref_data(input logic [31:0] inst, input logic [31:0] pc4,
                                            input logic [31:0] alu, input logic [31:0] dout);
      int unsigned off, b, h;
      off = alu % 4;
      b = (dout >> (8 * off)) & 32'hFF;
      h = (dout >> (16 * (off / 2))) & 32'hFFFF;
      case (inst[6:0])
         7'h03: case (inst[14:12])
            3'd0: return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'd4: return b;
            3'd1: return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'd5: return h;
            default: return dout;
         endcase
         7'h6F, 7'h67: return pc4;
         7'h37, 7'h17, 7'h33, 7'h13: return alu;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic ref_we(input logic v, input logic [31:0] inst);
      logic writes;
      writes = inst[6:0] inside {7'h33, 7'h13, 7'h03, 7'h6F, 7'h67, 7'h37, 7'h17};
      return v && (inst[11:7] != 5'd0) && writes;
   endfunction

   function automatic logic [31:0] gen_inst();
      logic [31:0] r;
      logic [6:0] ops [10];
      logic [2:0] f3s [6];
      ops = '{7'h33, 7'h13, 7'h03, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h23, 7'h63, 7'h73};
      f3s = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
      r = $urandom;
      r[6:0] = ops[$urandom_range(9, 0)];
      if (r[6:0] == 7'h03) r[14:12] = f3s[$urandom_range(5, 0)];
      if (r[6:0] == 7'h73) begin
         r[31:20] = ($urandom_range(3, 0) != 0) ? 12'h51E : 12'h340;
         r[14:12] = ($urandom_range(1, 0) != 0) ? 3'b001 : (($urandom_range(1, 0) != 0) ? 3'b101 : 3'b010);
      end
      return r;
   endfunction

   task automatic test_reset();
      reset = 1'b1; stall = 1'b0; x_valid = 1'b1; x_inst = 32'h0070_0293;
      x_pc = 32'h40; x_alu_out = 32'h7; x_csr_src = 32'h9; dcache_dout = 32'h0;
      tick();
      stall = 1'b1;
      tick();
      reset = 1'b0; stall = 1'b0; x_valid = 1'b0;
      #1;
      checks++; if (wb_inst !== NOP) begin failures++; $display("FAIL reset_wb_inst got=%h exp=%h", wb_inst, NOP); end
      checks++; if (wb_prev_inst !== NOP) begin failures++; $display("FAIL reset_prev_inst got=%h exp=%h", wb_prev_inst, NOP); end
      checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL reset_rf_we got=%b exp=0", rf_we); end
      checks++; if (csr_tohost !== 32'd0) begin failures++; $display("FAIL reset_tohost got=%h exp=0", csr_tohost); end
      checks++; if (wb_prev_data !== 32'd0) begin failures++; $display("FAIL reset_prev_data got=%h exp=0", wb_prev_data); end
   endtask

   task automatic test_alu();
      present(1'b1, 32'h0070_0293, 32'h100, 32'd7, 32'd0);
      checks++; if (rf_we !== 1'b1) begin failures++; $display("FAIL addi_rf_we got=%b exp=1", rf_we); end
      checks++; if (rf_wa !== 5'd5) begin failures++; $display("FAIL addi_rf_wa got=%0d exp=5", rf_wa); end
      checks++; if (rf_wd !== 32'd7) begin failures++; $display("FAIL addi_rf_wd got=%h exp=7", rf_wd); end
      present(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
      checks++; if (wb_prev_inst !== 32'h0070_0293) begin failures++; $display("FAIL addi_prev_inst got=%h exp=00700293", wb_prev_inst); end
      checks++; if (wb_prev_data !== 32'd7) begin failures++; $display("FAIL addi_prev_data got=%h exp=7", wb_prev_data); end
      checks++; if (wb_inst !== NOP) begin failures++; $display("FAIL bubble_wb_inst got=%h exp=%h", wb_inst, NOP); end
   endtask

   task automatic test_load_extract();
      logic [2:0]  f3  [6];
      logic [1:0]  off [6];
      logic [31:0] exp [6];
      f3  = '{3'd0, 3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
      off = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd0, 2'd3};
      exp = '{32'h0000_007F, 32'hFFFF_FFFF, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_7F01, 32'h80FF_7F01};
      for (int i = 0; i < 6; i++) begin
         dcache_dout = 32'h0;
         present(1'b1, {12'h0, 5'd0, f3[i], 5'd6, 7'h03}, 32'h200, {30'h40, off[i]}, 32'h0);
         dcache_dout = 32'h80FF_7F01;
         #1;
         checks++; if (rf_wd !== exp[i]) begin failures++; $display("FAIL load_extract_%0d got=%h exp=%h", i, rf_wd, exp[i]); end
         checks++; if (rf_we !== 1'b1) begin failures++; $display("FAIL load_we_%0d got=%b exp=1", i, rf_we); end
      end
   endtask

   task automatic test_stall();
      logic [31:0] ld, prev;
      ld = 32'h0000_2383;
      prev = wb_inst;
      present(1'b1, ld, 32'h300, 32'h400, 32'h0);
      dcache_dout = 32'h1234_5678;
      x_inst = 32'h0010_0093; x_valid = 1'b1; stall = 1'b1;
      #1;
      for (int c = 0; c < 3; c++) begin
         checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL stall_rf_we_%0d got=%b exp=0", c, rf_we); end
         tick();
         checks++; if (wb_inst !== ld) begin failures++; $display("FAIL stall_wb_inst_%0d got=%h exp=%h", c, wb_inst, ld); end
      end
      stall = 1'b0;
      #1;
      checks++; if (rf_we !== 1'b1) begin failures++; $display("FAIL unstall_rf_we got=%b exp=1", rf_we); end
      checks++; if (rf_wd !== 32'h1234_5678) begin failures++; $display("FAIL unstall_rf_wd got=%h exp=12345678", rf_wd); end
      checks++; if (wb_prev_inst !== prev) begin failures++; $display("FAIL unstall_prev_early got=%h exp=%h", wb_prev_inst, prev); end
      x_valid = 1'b0;
      tick();
      checks++; if (wb_prev_inst !== ld) begin failures++; $display("FAIL unstall_prev got=%h exp=%h", wb_prev_inst, ld); end
      checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL unstall_once got=%b exp=0", rf_we); end
   endtask

   task automatic test_tohost();
      logic [31:0] csrw, csrwi;
      csrw  = {12'h51E, 5'd1, 3'b001, 5'd0, 7'h73};
      csrwi = {12'h51E, 5'd5, 3'b101, 5'd0, 7'h73};
      present(1'b1, csrw, 32'h500, 32'h0, 32'd1);
      checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL csrw_rf_we got=%b exp=0", rf_we); end
      present(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
      checks++; if (csr_tohost !== 32'd1) begin failures++; $display("FAIL csrw_tohost got=%h exp=1", csr_tohost); end
      present(1'b1, csrwi, 32'h504, 32'h0, 32'hDEAD);
      present(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
      checks++; if (csr_tohost !== 32'd5) begin failures++; $display("FAIL csrwi_tohost got=%h exp=5", csr_tohost); end
      present(1'b0, csrw, 32'h508, 32'h0, 32'd1);
      present(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
      checks++; if (csr_tohost !== 32'd5) begin failures++; $display("FAIL flushed_csrw_tohost got=%h exp=5", csr_tohost); end
   endtask

   task automatic test_jal_branch();
      present(1'b1, 32'h0000_00EF, 32'h1000, 32'h1234, 32'h0);
      checks++; if (rf_wd !== 32'h1004) begin failures++; $display("FAIL jal_rf_wd got=%h exp=1004", rf_wd); end
      checks++; if (rf_we !== 1'b1) begin failures++; $display("FAIL jal_rf_we got=%b exp=1", rf_we); end
      present(1'b1, 32'h0000_0063, 32'h1004, 32'h1, 32'h0);
      checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL beq_rf_we got=%b exp=0", rf_we); end
      checks++; if (wb_prev_inst !== 32'h0000_00EF) begin failures++; $display("FAIL beq_prev got=%h exp=000000ef", wb_prev_inst); end
      present(1'b1, 32'h0000_2023, 32'h1008, 32'h80, 32'h0);
      checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL sw_rf_we got=%b exp=0", rf_we); end
      checks++; if (wb_prev_inst !== 32'h0000_0063) begin failures++; $display("FAIL sw_prev got=%h exp=00000063", wb_prev_inst); end
      present(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
      checks++; if (wb_prev_inst !== 32'h0000_2023) begin failures++; $display("FAIL sw_shift got=%h exp=00002023", wb_prev_inst); end
      present(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
      checks++; if (wb_prev_inst !== NOP) begin failures++; $display("FAIL bubble_shift got=%h exp=%h", wb_prev_inst, NOP); end
   endtask

   task automatic test_random();
      logic [31:0] m_inst, m_prev_inst, m_prev_data, m_pc4, m_alu, m_csr, m_tohost, exp_data;
      logic        m_valid, exp_we;
      reset = 1'b1; stall = 1'b0; x_valid = 1'b0;
      tick();
      reset = 1'b0;
      m_inst = NOP; m_prev_inst = NOP; m_prev_data = 0; m_pc4 = 0; m_alu = 0; m_csr = 0;
      m_tohost = 0; m_valid = 1'b0;
      for (int c = 0; c < 400; c++) begin
         stall = ($urandom_range(3, 0) == 0);
         x_valid = ($urandom_range(4, 0) != 0);
         x_inst = gen_inst();
         x_pc = $urandom & 32'hFFFF_FFFC;
         x_alu_out = $urandom;
         x_csr_src = $urandom;
         dcache_dout = $urandom;
         #1;
         exp_data = ref_data(m_inst, m_pc4, m_alu, dcache_dout);
         exp_we = ref_we(m_valid, m_inst) && !stall;
         checks++; if (wb_inst !== m_inst) begin failures++; $display("FAIL rnd_wb_inst c=%0d got=%h exp=%h", c, wb_inst, m_inst); end
         checks++; if (wb_prev_inst !== m_prev_inst) begin failures++; $display("FAIL rnd_prev_inst c=%0d got=%h exp=%h", c, wb_prev_inst, m_prev_inst); end
         checks++; if (wb_data !== exp_data) begin failures++; $display("FAIL rnd_wb_data c=%0d got=%h exp=%h", c, wb_data, exp_data); end
         checks++; if (rf_wd !== exp_data) begin failures++; $display("FAIL rnd_rf_wd c=%0d got=%h exp=%h", c, rf_wd, exp_data); end
         checks++; if (wb_prev_data !== m_prev_data) begin failures++; $display("FAIL rnd_prev_data c=%0d got=%h exp=%h", c, wb_prev_data, m_prev_data); end
         checks++; if (rf_we !== exp_we) begin failures++; $display("FAIL rnd_rf_we c=%0d got=%b exp=%b", c, rf_we, exp_we); end
         checks++; if (rf_wa !== m_inst[11:7]) begin failures++; $display("FAIL rnd_rf_wa c=%0d got=%0d exp=%0d", c, rf_wa, m_inst[11:7]); end
         checks++; if (csr_tohost !== m_tohost) begin failures++; $display("FAIL rnd_tohost c=%0d got=%h exp=%h", c, csr_tohost, m_tohost); end
         tick();
         if (!stall) begin
            if (m_valid && m_inst[6:0] == 7'h73 && m_inst[31:20] == 12'h51E) begin
               if (m_inst[14:12] == 3'b001) m_tohost = m_csr;
               else if (m_inst[14:12] == 3'b101) m_tohost = {27'b0, m_inst[19:15]};
            end
            m_prev_inst = m_inst;
            m_prev_data = exp_data;
            m_inst = x_valid ? x_inst : NOP;
            m_valid = x_valid;
            m_pc4 = x_pc + 32'd4;
            m_alu = x_alu_out;
            m_csr = x_csr_src;
         end
      end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_load_extract();
      test_stall();
      test_tohost();
      test_jal_branch();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
